// File: rtl/lc3_mem_sequencer.sv
// LC-3 memory-cycle sequencer: fetches one instruction, performs its 0-2 data accesses
// over a req/ack memory port and reports completion to the datapath.
module lc3_mem_sequencer #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [AW-1:0] pc_i,
    output logic          busy_o,
    output logic [2:0]    rf_addr_o,
    input  logic [DW-1:0] rf_data_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] ir_o,
    output logic [DW-1:0] ld_data_o,
    output logic [1:0]    acc_cnt_o,
    output logic          done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_SRC, S_IND, S_DATA, S_DONE
    } state_e;

    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_RTI  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_TRAP = 4'hF;

    function automatic logic [AW-1:0] sext9(input logic [8:0] v);
        return {{(AW-9){v[8]}}, v};
    endfunction

    function automatic logic [AW-1:0] sext6(input logic [5:0] v);
        return {{(AW-6){v[5]}}, v};
    endfunction

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d, ea_q, ea_d, addr_q, addr_d;
    logic [DW-1:0] ir_q, ir_d, wdata_q, wdata_d, ld_data_q, ld_data_d;
    logic [1:0]    acc_q, acc_d;
    logic [2:0]    rf_addr_q, rf_addr_d;
    logic          req_q, req_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [3:0]    op_s;
    logic          ack_s, access_s, is_store_s;

    // Next-state, effective-address and memory-request logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ea_d      = ea_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        wdata_d   = wdata_q;
        ld_data_d = ld_data_q;
        acc_d     = acc_q;
        req_d     = req_q;
        we_d      = we_q;
        rf_addr_d = 3'd0;
        op_s       = ir_q[15:12];
        is_store_s = (op_s == OP_ST) || (op_s == OP_STR) || (op_s == OP_STI);
        ack_s      = mem_ack_i && req_q;
        access_s   = (state_q == S_FETCH) || (state_q == S_IND) || (state_q == S_DATA);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_FETCH;
                    pc_d    = pc_i;
                    acc_d   = 2'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (ack_s) begin
                    ir_d    = mem_rdata_i;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_s)
                    OP_LD, OP_ST, OP_LDI, OP_STI: ea_d = pc_q + {{(AW-1){1'b0}}, 1'b1} + sext9(ir_q[8:0]);
                    OP_LDR, OP_STR:               ea_d = AW'(rf_data_i) + sext6(ir_q[5:0]);
                    OP_TRAP:                      ea_d = {{(AW-8){1'b0}}, ir_q[7:0]};
                    OP_RTI:                       ea_d = AW'(rf_data_i);
                    default:                      ea_d = ea_q;
                endcase
                case (op_s)
                    OP_LD, OP_LDR, OP_RTI, OP_TRAP: state_d = S_DATA;
                    OP_LDI:                         state_d = S_IND;
                    OP_ST, OP_STR, OP_STI:          state_d = S_SRC;
                    default:                        state_d = S_DONE;
                endcase
            end
            S_SRC: begin
                wdata_d = rf_data_i;
                state_d = (op_s == OP_STI) ? S_IND : S_DATA;
            end
            S_IND: begin
                if (ack_s) begin
                    ea_d    = AW'(mem_rdata_i);
                    state_d = S_DATA;
                end else begin
                    state_d = S_IND;
                end
            end
            S_DATA: begin
                if (ack_s) begin
                    if (!we_q) begin
                        ld_data_d = mem_rdata_i;
                    end else begin
                        ld_data_d = ld_data_q;
                    end
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Request rises one cycle after entering an access state and drops on its ack
        if (access_s && !req_q) begin
            req_d  = 1'b1;
            addr_d = (state_q == S_FETCH) ? pc_q : ea_q;
            we_d   = (state_q == S_DATA) && is_store_s;
        end else if (ack_s) begin
            req_d = 1'b0;
            we_d  = 1'b0;
            acc_d = (acc_q == 2'd3) ? acc_q : acc_q + 2'd1;
        end else begin
            req_d = req_q;
        end

        // Register-file index is registered so it is ready in the cycle that reads it
        if (state_d == S_DECODE) begin
            case (ir_d[15:12])
                OP_LDR, OP_STR: rf_addr_d = ir_d[8:6];
                OP_RTI:         rf_addr_d = 3'd6;
                default:        rf_addr_d = 3'd0;
            endcase
        end else if (state_d == S_SRC) begin
            rf_addr_d = ir_q[11:9];
        end else begin
            rf_addr_d = 3'd0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= {AW{1'b0}};
            ea_q      <= {AW{1'b0}};
            addr_q    <= {AW{1'b0}};
            ir_q      <= {DW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            ld_data_q <= {DW{1'b0}};
            acc_q     <= 2'd0;
            rf_addr_q <= 3'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ea_q      <= ea_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            wdata_q   <= wdata_d;
            ld_data_q <= ld_data_d;
            acc_q     <= acc_d;
            rf_addr_q <= rf_addr_d;
            req_q     <= req_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign rf_addr_o   = rf_addr_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ir_o        = ir_q;
    assign ld_data_o   = ld_data_q;
    assign acc_cnt_o   = acc_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Directed bench for lc3_mem_sequencer: per-instruction vector table against a
// behavioural memory/register-file model, plus reset, held-start and stray-ack sequences.
module tb_lc3_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] pc_i = 16'h0000;
    logic        busy_o, mem_req_o, mem_we_o, done_o;
    logic [2:0]  rf_addr_o;
    logic [15:0] rf_data_i, mem_addr_o, mem_wdata_o, mem_rdata_i, ir_o, ld_data_o;
    logic        mem_ack_i;
    logic [1:0]  acc_cnt_o;

    lc3_mem_sequencer #(.AW(16), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .pc_i(pc_i), .busy_o(busy_o),
        .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .ir_o(ir_o),
        .ld_data_o(ld_data_o), .acc_cnt_o(acc_cnt_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic [15:0] rf  [0:7];
    assign rf_data_i = rf[rf_addr_o];

    logic        ack_r = 1'b0;
    logic        force_ack = 1'b0;
    logic [15:0] rdata_r = 16'h0000;
    assign mem_ack_i   = ack_r | force_ack;
    assign mem_rdata_i = rdata_r;

    int          waits = 0;
    int          wcnt = 0;
    int          stab_err = 0;
    bit          pend = 1'b0;
    logic [15:0] p_addr, p_wd;
    logic        p_we;
    logic [15:0] lg_addr[$];
    logic [15:0] lg_data[$];
    logic        lg_we[$];

    int checks = 0;
    int errors = 0;

    // Memory responder: inserts wait states, checks request stability, logs completed accesses
    always @(negedge clk) begin
        if (!rst_n || !mem_req_o) begin
            ack_r = 1'b0;
            wcnt  = 0;
            pend  = 1'b0;
        end else begin
            if (pend && (mem_addr_o !== p_addr || mem_we_o !== p_we || mem_wdata_o !== p_wd))
                stab_err++;
            if (wcnt < waits) begin
                wcnt++;
                ack_r  = 1'b0;
                pend   = 1'b1;
                p_addr = mem_addr_o;
                p_we   = mem_we_o;
                p_wd   = mem_wdata_o;
            end else begin
                ack_r = 1'b1;
                wcnt  = 0;
                pend  = 1'b0;
                if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
                rdata_r = mem_we_o ? 16'h0000 : mem[mem_addr_o];
                lg_addr.push_back(mem_addr_o);
                lg_we.push_back(mem_we_o);
                lg_data.push_back(mem_we_o ? mem_wdata_o : mem[mem_addr_o]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] ir, pc, ma_a, ma_d, mb_a, mb_d, ra_d, rb_d;
        int          ra_i, rb_i, waits, lat;
        logic [1:0]  acc;
        logic [15:0] ea;
        logic        we;
        logic [15:0] data;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [15:0] ir, input logic [15:0] pc,
                                input logic [15:0] ma_a, input logic [15:0] ma_d,
                                input logic [15:0] mb_a, input logic [15:0] mb_d,
                                input int ra_i, input logic [15:0] ra_d,
                                input int rb_i, input logic [15:0] rb_d,
                                input int w, input int lat, input logic [1:0] acc,
                                input logic [15:0] ea, input logic we, input logic [15:0] data);
        vec_t v;
        v.name = n; v.ir = ir; v.pc = pc; v.ma_a = ma_a; v.ma_d = ma_d; v.mb_a = mb_a;
        v.mb_d = mb_d; v.ra_i = ra_i; v.ra_d = ra_d; v.rb_i = rb_i; v.rb_d = rb_d;
        v.waits = w; v.lat = lat; v.acc = acc; v.ea = ea; v.we = we; v.data = data;
        return v;
    endfunction

    task automatic setup(input vec_t v);
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
        rf[v.ra_i] = v.ra_d;
        rf[v.rb_i] = v.rb_d;
        mem[v.ma_a] = v.ma_d;
        mem[v.mb_a] = v.mb_d;
        mem[v.pc]   = v.ir;
        waits = v.waits;
        lg_addr.delete(); lg_we.delete(); lg_data.delete();
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (!busy_o) got = 1'b1;
        end
        check("idle_before_start", {31'd0, got}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat = 0;
        bit got = 1'b0;
        setup(v);
        wait_idle();
        pc_i = v.pc;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done_o) got = 1'b1;
        end
        check({v.name, "_done"}, {31'd0, got}, 32'd1);
        check({v.name, "_latency"}, lat, v.lat);
        check({v.name, "_busy_at_done"}, {31'd0, busy_o}, 32'd1);
        check({v.name, "_acc_cnt"}, {30'd0, acc_cnt_o}, {30'd0, v.acc});
        check({v.name, "_ir"}, {16'd0, ir_o}, {16'd0, v.ir});
        check({v.name, "_n_access"}, lg_addr.size(), {30'd0, v.acc});
        if (lg_addr.size() > 0) begin
            check({v.name, "_last_addr"}, {16'd0, lg_addr[$]}, {16'd0, v.ea});
            check({v.name, "_last_we"}, {31'd0, lg_we[$]}, {31'd0, v.we});
            check({v.name, "_last_data"}, {16'd0, lg_data[$]}, {16'd0, v.data});
            check({v.name, "_first_addr"}, {16'd0, lg_addr[0]}, {16'd0, v.pc});
        end
        if (!v.we && v.acc > 2'd1) check({v.name, "_ld_data"}, {16'd0, ld_data_o}, {16'd0, v.data});
        @(posedge clk); #1;
        check({v.name, "_done_pulse"}, {31'd0, done_o}, 32'd0);
        check({v.name, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        vec_t hv;
        bit got;
        logic [15:0] ld_keep;
        logic [1:0]  acc_keep;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

        //            name       ir        pc        ma_a      ma_d      mb_a      mb_d      ra rad       rb rbd       w  lat acc ea        we    data
        vecs[0]  = mk("add",     16'h1261, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 3,  2'd1, 16'h3000, 1'b0, 16'h1261);
        vecs[1]  = mk("ld",      16'h2205, 16'h3000, 16'h3006, 16'hBEEF, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 5,  2'd2, 16'h3006, 1'b0, 16'hBEEF);
        vecs[2]  = mk("ld_wrap", 16'h25FF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 5,  2'd2, 16'h0000, 1'b0, 16'h25FF);
        vecs[3]  = mk("ldi",     16'hA202, 16'h3000, 16'h3003, 16'h4000, 16'h4000, 16'hCAFE, 0, 16'h0000, 0, 16'h0000, 0, 7,  2'd3, 16'h4000, 1'b0, 16'hCAFE);
        vecs[4]  = mk("ldi_self",16'hA3FF, 16'h3010, 16'hA3FF, 16'h5A5A, 16'hA3FF, 16'h5A5A, 0, 16'h0000, 0, 16'h0000, 0, 7,  2'd3, 16'hA3FF, 1'b0, 16'h5A5A);
        vecs[5]  = mk("st",      16'h3204, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 6,  2'd2, 16'h3005, 1'b1, 16'h1234);
        vecs[6]  = mk("str",     16'h7282, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2, 16'hFFFF, 1, 16'h1234, 0, 6,  2'd2, 16'h0001, 1'b1, 16'h1234);
        vecs[7]  = mk("sti",     16'hB201, 16'h3000, 16'h3002, 16'h5000, 16'h0000, 16'h0000, 1, 16'h9876, 0, 16'h0000, 0, 8,  2'd3, 16'h5000, 1'b1, 16'h9876);
        vecs[8]  = mk("ldr",     16'h6283, 16'h3000, 16'h0002, 16'h1111, 16'h0000, 16'h0000, 2, 16'hFFFF, 0, 16'h0000, 0, 5,  2'd2, 16'h0002, 1'b0, 16'h1111);
        vecs[9]  = mk("rti",     16'h8000, 16'h3000, 16'h2FFE, 16'h7777, 16'h0000, 16'h0000, 6, 16'h2FFE, 0, 16'h0000, 0, 5,  2'd2, 16'h2FFE, 1'b0, 16'h7777);
        vecs[10] = mk("trap_ws", 16'hF025, 16'h3000, 16'h0025, 16'h0400, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 5, 15, 2'd2, 16'h0025, 1'b0, 16'h0400);
        vecs[11] = mk("br",      16'h0E00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 3,  2'd1, 16'h4000, 1'b0, 16'h0E00);
        vecs[12] = mk("jmp",     16'hC1C0, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000, 2, 5,  2'd1, 16'h3000, 1'b0, 16'hC1C0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_acc", {30'd0, acc_cnt_o}, 32'd0);
        check("rst_ir_ld", {ir_o, ld_data_o}, 32'd0);
        check("rst_addr_wd", {mem_addr_o, mem_wdata_o}, 32'd0);
        check("rst_we_rf", {28'd0, mem_we_o, rf_addr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Stray ack while idle must not disturb anything
        ld_keep  = ld_data_o;
        acc_keep = acc_cnt_o;
        @(negedge clk);
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        force_ack = 1'b0;
        check("stray_ack_busy", {31'd0, busy_o}, 32'd0);
        check("stray_ack_acc", {30'd0, acc_cnt_o}, {30'd0, acc_keep});
        check("stray_ack_ld", {16'd0, ld_data_o}, {16'd0, ld_keep});

        // start held through the whole instruction, including its DONE cycle
        hv = vecs[1];
        setup(hv);
        wait_idle();
        pc_i = hv.pc;
        start_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            if (done_o) got = 1'b1;
        end
        check("hold_done", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_busy_after", {31'd0, busy_o}, 32'd0);
        check("hold_n_access", lg_addr.size(), 32'd2);

        // Reset asserted while STI waits on its indirect read
        hv = vecs[7];
        hv.waits = 5;
        mem[16'h5000] = 16'h0000;
        setup(hv);
        wait_idle();
        pc_i = hv.pc;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_addr_o == 16'h3002) got = 1'b1;
        end
        check("sti_ind_reached", {31'd0, got}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req_o}, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_acc", {30'd0, acc_cnt_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0]);
        check("arst_no_write", {16'd0, mem[16'h5000]}, 32'd0);

        check("hold_stable", stab_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
